// File: rtl/key_expand_seq.sv
// AES-128 key-schedule engine: four S-box lanes on RotWord(w3), one 32-bit word per clock,
// round keys 0..10 delivered over valid/ready. Define KEYEXP_ABORT_EN to add the abort input.

module key_sbox_lane (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    // Forward AES S-box; entry n sits in bits [2047-8n -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // 2047 - 8n equals the 11-bit complement of {n, 3'b000}.
    assign dout = SBOX_TABLE[{~din, 3'b111} -: 8];
endmodule

module key_expand_seq #(
    parameter int         NUM_ROUNDS = 10,
    parameter logic [7:0] RCON_INIT  = 8'h01
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] keyIn,
    input  logic         rkReady,
`ifdef KEYEXP_ABORT_EN
    input  logic         abort,
`endif
    output logic         rkValid,
    output logic [127:0] rkData,
    output logic [3:0]   rkIndex,
    output logic         busy,
    output logic         done
);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_GEN,
        ST_FIN
    } state_t;

    state_t      state_reg;
    logic [31:0] w_reg [4];
    logic [1:0]  word_cnt_reg;
    logic [3:0]  round_reg;
    logic [7:0]  rcon_reg;
    logic        rk_valid_reg;
    logic        busy_reg;
    logic        done_reg;

    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [31:0] t_word;
    logic [31:0] gen_word;
    logic [7:0]  rcon_next;
    logic        abort_hit;

`ifdef KEYEXP_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign rot_word = {w_reg[3][23:0], w_reg[3][31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            key_sbox_lane u_lane (
                .din  (rot_word[8*gi +: 8]),
                .dout (sub_word[8*gi +: 8])
            );
        end
    endgenerate

    assign t_word    = sub_word ^ {rcon_reg, 24'h000000};
    assign rcon_next = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);

    // Word k chains off the word updated on the previous edge; word 0 takes the g() term.
    always_comb begin
        gen_word = w_reg[word_cnt_reg] ^ w_reg[word_cnt_reg - 2'd1];
        if (word_cnt_reg == 2'd0) begin
            gen_word = w_reg[0] ^ t_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            for (int k = 0; k < 4; k++) begin
                w_reg[k] <= 32'h0;
            end
            word_cnt_reg <= 2'd0;
            round_reg    <= 4'd0;
            rcon_reg     <= RCON_INIT;
            rk_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else if (abort_hit && state_reg != ST_IDLE) begin
            state_reg    <= ST_IDLE;
            rk_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        for (int k = 0; k < 4; k++) begin
                            w_reg[k] <= keyIn[127-32*k -: 32];
                        end
                        round_reg    <= 4'd0;
                        rcon_reg     <= RCON_INIT;
                        rk_valid_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                        state_reg    <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (rkReady) begin
                        rk_valid_reg <= 1'b0;
                        if (round_reg == LAST_ROUND) begin
                            done_reg  <= 1'b1;
                            state_reg <= ST_FIN;
                        end else begin
                            word_cnt_reg <= 2'd0;
                            state_reg    <= ST_GEN;
                        end
                    end
                end
                ST_GEN: begin
                    w_reg[word_cnt_reg] <= gen_word;
                    word_cnt_reg        <= word_cnt_reg + 2'd1;
                    if (word_cnt_reg == 2'd3) begin
                        round_reg    <= round_reg + 4'd1;
                        rcon_reg     <= rcon_next;
                        rk_valid_reg <= 1'b1;
                        state_reg    <= ST_EMIT;
                    end
                end
                ST_FIN: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign rkValid = rk_valid_reg;
    assign rkData  = {w_reg[0], w_reg[1], w_reg[2], w_reg[3]};
    assign rkIndex = round_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
endmodule
